mem_store: RTL and testbench



---
 rtl/mem_store_pkg.sv | 16 +
 rtl/mem_store.sv | 107 ++++++++++
 tb/tb_mem_store.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_store_pkg.sv
// Shared state encodings and width helper for the linear-memory store/read paths.
package mem_store_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   // Data bus width for a request carrying up to 2**extra bytes.
   function automatic int data_w(input int extra);
      return (2 ** extra) * 8;
   endfunction

endpackage

// File: rtl/mem_store.sv
// Byte-serial little-endian store engine feeding a byte-wide RAM write port.
// Define MEM_STORE_BOUNDS_EN to enable the lower/upper bounds fault check.
module mem_store
   import mem_store_pkg::*;
#(
   parameter int AW    = 6,
   parameter int EXTRA = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [AW:0]                req_addr,
   input  logic [EXTRA-1:0]           req_extra,
   input  logic [data_w(EXTRA)-1:0]   req_data,
   input  logic [AW:0]                lower_bound,
   input  logic [AW:0]                upper_bound,
   output logic                       ram_we,
   output logic [AW:0]                ram_addr,
   output logic [7:0]                 ram_wdata,
   output logic                       done,
   output logic                       error
);

   localparam int NB = 2 ** EXTRA;
   typedef logic [NB-1:0][7:0] bytes_t;

   state_t           state, state_nxt;
   logic [EXTRA-1:0] cnt, cnt_nxt, extra_q;
   logic [AW:0]      addr_q, base, addr_d;
   bytes_t           data_q, src;
   logic             accept, fault;
   logic             ready_d, we_d, done_d, error_d;
   logic [7:0]       wdata_d;

   assign accept = req_valid && (state == ST_IDLE);

`ifdef MEM_STORE_BOUNDS_EN
   logic [AW+1:0] end_addr;
   assign end_addr = {1'b0, req_addr} + (AW+2)'(req_extra);
   // A carry out of AW+1 bits is always a fault, so the low bits suffice for the upper compare.
   assign fault = (req_addr < lower_bound) || end_addr[AW+1] || (end_addr[AW:0] > upper_bound);
`else
   logic unused_bounds;
   assign unused_bounds = ^{lower_bound, upper_bound};
   assign fault = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = fault ? ST_FAULT : ST_WRITE;
         ST_WRITE: if (cnt == extra_q) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         ST_FAULT: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are computed for the upcoming cycle and registered, so the first
   // byte is taken straight from the request inputs on acceptance.
   always_comb begin
      base    = (state == ST_IDLE) ? req_addr : addr_q;
      src     = (state == ST_IDLE) ? bytes_t'(req_data) : data_q;
      cnt_nxt = (state == ST_WRITE && state_nxt == ST_WRITE) ? cnt + EXTRA'(1) : '0;
      ready_d = (state_nxt == ST_IDLE);
      we_d    = (state_nxt == ST_WRITE);
      done_d  = (state_nxt == ST_DONE);
      error_d = (state_nxt == ST_FAULT);
      addr_d  = we_d ? base + (AW+1)'(cnt_nxt) : '0;
      wdata_d = we_d ? src[cnt_nxt] : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         extra_q   <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         req_ready <= 1'b1;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= req_addr;
            extra_q <= req_extra;
            data_q  <= req_data;
         end
         cnt       <= cnt_nxt;
         req_ready <= ready_d;
         ram_we    <= we_d;
         ram_addr  <= addr_d;
         ram_wdata <= wdata_d;
         done      <= done_d;
         error     <= error_d;
      end
   end

endmodule

// File: tb/tb_mem_store.sv
// Self-checking bench for mem_store: queue-based reference model plus directed literal checks.
module tb_mem_store;

   localparam int AW    = 6;
   localparam int EXTRA = 4;
   localparam int NB    = 2 ** EXTRA;
   localparam int AMAX  = 2 ** (AW + 1);

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready, ram_we, done, error;
   logic [AW:0]       req_addr = '0;
   logic [AW:0]       lower_bound = '0;
   logic [AW:0]       upper_bound = '1;
   logic [AW:0]       ram_addr;
   logic [EXTRA-1:0]  req_extra = '0;
   logic [NB*8-1:0]   req_data = '0;
   logic [7:0]        ram_wdata;

   mem_store #(.AW(AW), .EXTRA(EXTRA)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_extra(req_extra), .req_data(req_data),
      .lower_bound(lower_bound), .upper_bound(upper_bound),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        ready;
      logic        we;
      logic [AW:0] addr;
      logic [7:0]  wdata;
      logic        done;
      logic        error;
   } obs_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int done_cyc = 0;
   int err_cyc = 0;
   int n_done = 0;
   int n_err = 0;
   obs_t exp_q[$];
   logic [AW+8:0] wr_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected output sequence for a request, straight from the byte-order and bounds rules.
   task automatic model_accept();
      int   first, last;
      bit   fault;
      obs_t e;
      first = int'(req_addr);
      last  = first + int'(req_extra);
      fault = 1'b0;
`ifdef MEM_STORE_BOUNDS_EN
      fault = (first < int'(lower_bound)) || (last > int'(upper_bound)) || (last >= AMAX);
`endif
      if (fault) begin
         e = '0; e.error = 1'b1;
         exp_q.push_back(e);
      end else begin
         for (int i = 0; i <= int'(req_extra); i++) begin
            e = '0;
            e.we    = 1'b1;
            e.addr  = (AW+1)'((first + i) % AMAX);
            e.wdata = req_data[8*i +: 8];
            exp_q.push_back(e);
         end
         e = '0; e.done = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   // Model: queue front is what the outputs must show in the current cycle; empty means idle.
   always @(posedge clk) begin
      bit acc;
      if (reset) exp_q.delete();
      else begin
         acc = req_valid && (exp_q.size() == 0);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         if (acc) model_accept();
      end
   end

   always @(negedge clk) begin
      obs_t a, e;
      cyc++;
      a = '{req_ready, ram_we, ram_addr, ram_wdata, done, error};
      e = '0;
      e.ready = 1'b1;
      if (!reset && exp_q.size() != 0) e = exp_q[0];
      chk("cycle_outputs", 32'(a), 32'(e));
      if (ram_we) wr_log.push_back({ram_addr, ram_wdata});
      if (done) begin n_done++; done_cyc = cyc; end
      if (error) begin n_err++; err_cyc = cyc; end
   end

   task automatic wait_accept();
      bit got;
      got = 1'b0;
      for (int n = 0; n < 64 && !got; n++) begin
         @(negedge clk);
         if (req_ready) got = 1'b1;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL accept_timeout: req_ready=%b, required 1", req_ready);
      end
      @(posedge clk);
      acc_cyc = cyc;
      #2;
   endtask

   task automatic issue(input logic [AW:0] a, input int ex, input logic [NB*8-1:0] d,
                        input logic [AW:0] lo, input logic [AW:0] hi, input bit hold);
      req_addr    = a;
      req_extra   = EXTRA'(ex);
      req_data    = d;
      lower_bound = lo;
      upper_bound = hi;
      req_valid   = 1'b1;
      wait_accept();
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd, ne, accA;
      #1 reset = 1'b1;
      #3;
      chk("reset_ready", 32'(req_ready), 32'd1);
      chk("reset_we", 32'(ram_we), 32'd0);
      chk("reset_addr", 32'(ram_addr), 32'd0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      settle(2);

      // i32 store
      wr_log.delete(); nd = n_done; ne = n_err;
      issue(7'd4, 3, 128'h11223344, 7'd0, 7'd127, 1'b0);
      settle(8);
      chk("i32_nwrites", 32'(wr_log.size()), 32'd4);
      chk("i32_w0", 32'(wr_log[0]), 32'({7'd4, 8'h44}));
      chk("i32_w1", 32'(wr_log[1]), 32'({7'd5, 8'h33}));
      chk("i32_w2", 32'(wr_log[2]), 32'({7'd6, 8'h22}));
      chk("i32_w3", 32'(wr_log[3]), 32'({7'd7, 8'h11}));
      chk("i32_done_lat", 32'(done_cyc - acc_cyc), 32'd5);
      chk("i32_ndone", 32'(n_done - nd), 32'd1);
      chk("i32_nerr", 32'(n_err - ne), 32'd0);

      // single byte: done at k+2, ready at k+3
      wr_log.delete();
      issue(7'd0, 0, 128'hAB, 7'd0, 7'd127, 1'b0);
      @(negedge clk); chk("sb_ready_k1", 32'(req_ready), 32'd0);
      chk("sb_write", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 7'd0, 8'hAB}));
      @(negedge clk); chk("sb_done_k2", 32'({req_ready, done}), 32'b01);
      @(negedge clk); chk("sb_ready_k3", 32'(req_ready), 32'd1);
      settle(2);

      // upper-bound fault (wraps when bounds checking is compiled out)
      wr_log.delete(); ne = n_err;
      issue(7'd125, 7, 128'h8877665544332211, 7'd0, 7'd127, 1'b0);
      settle(12);
`ifdef MEM_STORE_BOUNDS_EN
      chk("upper_err", 32'(n_err - ne), 32'd1);
      chk("upper_err_lat", 32'(err_cyc - acc_cyc), 32'd1);
      chk("upper_nwrites", 32'(wr_log.size()), 32'd0);
`else
      chk("upper_nwrites", 32'(wr_log.size()), 32'd8);
      chk("upper_wrap", 32'(wr_log[3]), 32'({7'd0, 8'h44}));
      chk("upper_noerr", 32'(n_err - ne), 32'd0);
`endif

      // lower-bound fault
      wr_log.delete(); ne = n_err;
      issue(7'd3, 0, 128'h5A, 7'd8, 7'd127, 1'b0);
      settle(5);
`ifdef MEM_STORE_BOUNDS_EN
      chk("lower_err", 32'(n_err - ne), 32'd1);
      chk("lower_nwrites", 32'(wr_log.size()), 32'd0);
`else
      chk("lower_write", 32'(wr_log[0]), 32'({7'd3, 8'h5A}));
`endif

      // back-to-back with valid held and request changed during WRITE
      wr_log.delete();
      issue(7'd10, 3, 128'hA1A2A3A4, 7'd0, 7'd127, 1'b1);
      accA = acc_cyc;
      req_addr  = 7'd40;
      req_extra = EXTRA'(1);
      req_data  = 128'hB1B2B3B4;
      wait_accept();
      req_valid = 1'b0;
      chk("b2b_spacing", 32'(acc_cyc - accA), 32'd6);
      settle(6);
      chk("b2b_nwrites", 32'(wr_log.size()), 32'd6);
      chk("b2b_a0", 32'(wr_log[0]), 32'({7'd10, 8'hA4}));
      chk("b2b_a3", 32'(wr_log[3]), 32'({7'd13, 8'hA1}));
      chk("b2b_b0", 32'(wr_log[4]), 32'({7'd40, 8'hB4}));
      chk("b2b_b1", 32'(wr_log[5]), 32'({7'd41, 8'hB3}));

      // reset after the third byte of an i64 store
      wr_log.delete(); nd = n_done;
      issue(7'd16, 7, 128'h0807060504030201, 7'd0, 7'd127, 1'b0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      settle(12);
      chk("rst_nwrites", 32'(wr_log.size()), 32'd3);
      chk("rst_nodone", 32'(n_done - nd), 32'd0);
      wr_log.delete();
      issue(7'd20, 1, 128'hBEEF, 7'd0, 7'd127, 1'b0);
      settle(5);
      chk("post_rst_w0", 32'(wr_log[0]), 32'({7'd20, 8'hEF}));
      chk("post_rst_w1", 32'(wr_log[1]), 32'({7'd21, 8'hBE}));

      // randomized traffic checked cycle by cycle against the model
      for (int it = 0; it < 80; it++) begin
         logic [NB*8-1:0] d;
         bit hold;
         d = {$urandom, $urandom, $urandom, $urandom};
         hold = ($urandom_range(0, 3) == 0);
         issue(7'($urandom_range(0, AMAX-1)), int'($urandom_range(0, NB-1)), d,
               7'($urandom_range(0, 16)), 7'($urandom_range(96, AMAX-1)), hold);
         if (hold) begin
            req_addr = 7'($urandom);
            req_data = {$urandom, $urandom, $urandom, $urandom};
         end
         settle(int'($urandom_range(0, 3)));
      end
      req_valid = 1'b0;
      settle(25);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
